button_debouncer: RTL and testbench
===================================

# button_debouncer

Multi-channel synchronizer and debouncer for raw push-button and switch inputs on the board top level, placed between the FPGA pins and the `rvsteel` `reset`/`halt` ports. Each channel passes through a two-flop synchronizer, then a per-channel stability counter. A level change reaches the output only after it has held for `DEBOUNCE_CYCLES` consecutive clocks. Optional single-cycle press/release pulses serve consumers that need edges rather than levels.

## Interface
- `NUM_BUTTONS`, default 2: number of independent channels; ≥1.
- `DEBOUNCE_CYCLES`, default 120000: consecutive clocks a synchronized level must hold before it is accepted (10 ms at 12 MHz); ≥1.
- `RESET_LEVEL`, default 0: value loaded into the synchronizers and `debounced` outputs on reset (one bit, applied to all channels).

- `clock`  input  1  system clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-high reset of this block.
- `button_raw`  input  NUM_BUTTONS  asynchronous pin levels, may bounce.
- `debounced`  output  NUM_BUTTONS  accepted stable level per channel, registered.
- `press_pulse`  output  NUM_BUTTONS  one-cycle pulse on a 0→1 change of `debounced`.
- `release_pulse`  output  NUM_BUTTONS  one-cycle pulse on a 1→0 change of `debounced`.

## Operation
- Per channel: `sync1 <= button_raw[i]`, `sync2 <= sync1`. Only `sync2` is used downstream.
- Each channel has its own counter, width `$clog2(DEBOUNCE_CYCLES+1)`, reset to 0.
- Each clock, per channel:
  - `sync2 == debounced[i]`: counter ← 0.
  - `sync2 != debounced[i]` and counter == `DEBOUNCE_CYCLES-1`: `debounced[i]` ← `sync2`, counter ← 0, and the matching edge pulse is asserted for this cycle.
  - otherwise: counter ← counter+1.
- A bounce back to the current `debounced` value before the threshold clears the counter. Disagreement must then restart from zero; there is no accumulation across glitches.
- Counter never exceeds `DEBOUNCE_CYCLES-1`; no wrap-around is possible.
- Channels are fully independent. Simultaneous changes on several channels are each handled on their own counters in the same cycle.
- Reset, asynchronous and any time including mid-count:
  - sync1, sync2 and `debounced` ← `RESET_LEVEL`
  - counters ← 0
  - `press_pulse` and `release_pulse` ← 0
- After reset deassertion, a pin already at the opposite level is debounced normally. It produces a pulse after the full latency.

## Timing
- Reset values: `debounced` = {NUM_BUTTONS{RESET_LEVEL}}, `press_pulse` = 0, `release_pulse` = 0.
- Latency: `button_raw` changes before rising edge E0 and then holds. `sync2` shows the new level after E1. `debounced` updates at edge E(DEBOUNCE_CYCLES+1) and is visible in the following cycle.
- Pulses are registered and high for exactly the one cycle in which the new `debounced` value first appears. They are never asserted two cycles in a row on the same channel.
- Minimum accepted pulse width at the pin: `DEBOUNCE_CYCLES` clocks. Narrower pulses never reach the output.
- No combinational path from `button_raw` to any output.

## Configuration
- `BUTTON_DEBOUNCER_EDGE_EN` defined: press/release pulse registers and logic are compiled in, as described above.
- Not defined: `press_pulse` and `release_pulse` are tied to constant 0 and their registers are omitted. `debounced` behaviour and latency are unchanged.

## Test plan
- Reset level: `NUM_BUTTONS`=2, `DEBOUNCE_CYCLES`=4, `RESET_LEVEL`=0. Assert `reset` mid-cycle with `button_raw`=2'b11 → `debounced`=0 and pulses=0 immediately. After release, `debounced`=2'b11 after edge 5 counted from the first post-reset edge.
- Clean press: ch0 0→1 held, `DEBOUNCE_CYCLES`=4 → `debounced[0]` rises after E5. `press_pulse[0]`=1 for exactly that one cycle. ch1 stays 0.
- Glitch rejection: ch0 high for 3 clocks, low for 1, high for 3, then low → `debounced[0]` stays 0 and no pulses occur.
- Release and independence: ch0 released while ch1 pressed in the same cycle → both update at the same edge. `release_pulse`=2'b01 and `press_pulse`=2'b10 for one cycle.
- Reset mid-count: ch0 differing for 3 of 4 cycles, then `reset` pulsed → counter cleared. After reset, a full 4-cycle hold plus 2 sync cycles is required before `debounced` changes.
- Macro off: rerun the clean-press case without `BUTTON_DEBOUNCER_EDGE_EN` → `debounced` timing identical, `press_pulse`/`release_pulse` constant 0.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Pin-side bundle for button_debouncer: raw levels in, debounced levels and edge pulses out.
interface button_debouncer_if #(
    parameter int NUM_BUTTONS = 2
);
    logic [NUM_BUTTONS-1:0] button_raw;
    logic [NUM_BUTTONS-1:0] debounced;
    logic [NUM_BUTTONS-1:0] press_pulse;
    logic [NUM_BUTTONS-1:0] release_pulse;

    modport master (
        output button_raw,
        input  debounced,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  button_raw,
        output debounced,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/button_debouncer.sv
// Multi-channel two-flop synchroniser plus per-channel stability counter.
// Define BUTTON_DEBOUNCER_EDGE_EN to build the registered press/release pulses.
module button_debouncer #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input logic               clock,
    input logic               reset,
    button_debouncer_if.slave btn
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;
    logic [NUM_BUTTONS-1:0] deb_q;
    logic [NUM_BUTTONS-1:0] deb_next;
    logic [CNT_W-1:0]       cnt_q    [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_next [NUM_BUTTONS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= {NUM_BUTTONS{RESET_LEVEL}};
            sync2 <= {NUM_BUTTONS{RESET_LEVEL}};
        end else begin
            sync1 <= btn.button_raw;
            sync2 <= sync1;
        end
    end

    // Any agreement with the accepted level clears the count, so glitches never accumulate.
    always_comb begin
        deb_next = deb_q;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            deb_q <= {NUM_BUTTONS{RESET_LEVEL}};
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_next;
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= cnt_next[i];
            end
        end
    end

    assign btn.debounced = deb_q;

`ifdef BUTTON_DEBOUNCER_EDGE_EN
    logic [NUM_BUTTONS-1:0] press_q;
    logic [NUM_BUTTONS-1:0] release_q;

    // Pulses share the edge that loads deb_q, so they line up with the new level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= deb_next & ~deb_q;
            release_q <= ~deb_next & deb_q;
        end
    end

    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
`else
    assign btn.press_pulse   = '0;
    assign btn.release_pulse = '0;
`endif
endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer against a sliding-window reference model.
module tb_button_debouncer;
    localparam int N  = 2;
    localparam int D  = 4;
    localparam bit RL = 1'b0;

    logic clock = 1'b0;
    logic reset;

    button_debouncer_if #(.NUM_BUTTONS(N)) bus ();

    button_debouncer #(
        .NUM_BUTTONS    (N),
        .DEBOUNCE_CYCLES(D),
        .RESET_LEVEL    (RL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn  (bus)
    );

    always #5 clock = ~clock;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model: a level is accepted once the last D synchronised samples all oppose it.
    logic [N-1:0] m_pipe1, m_pipe2, m_deb, m_press, m_release;
    logic [N-1:0] hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe1   = {N{RL}};
        m_pipe2   = {N{RL}};
        m_deb     = {N{RL}};
        m_press   = '0;
        m_release = '0;
        hist.delete();
    endtask

    task automatic model_step();
        bit all_opp;
        hist.push_back(m_pipe2);
        if (hist.size() > D) void'(hist.pop_front());
        m_press   = '0;
        m_release = '0;
        for (int unsigned ch = 0; ch < N; ch++) begin
            if (hist.size() == D) begin
                all_opp = 1'b1;
                for (int unsigned j = 0; j < D; j++)
                    if (hist[j][ch] == m_deb[ch]) all_opp = 1'b0;
                if (all_opp) begin
                    m_deb[ch] = ~m_deb[ch];
                    if (m_deb[ch]) m_press[ch] = 1'b1;
                    else           m_release[ch] = 1'b1;
                end
            end
        end
        m_pipe2 = m_pipe1;
        m_pipe1 = bus.button_raw;
    endtask

    task automatic compare_all(input string tag);
        logic [N-1:0] ep, er;
`ifdef BUTTON_DEBOUNCER_EDGE_EN
        ep = m_press;
        er = m_release;
`else
        ep = '0;
        er = '0;
`endif
        check({tag, ".debounced"}, 32'(bus.debounced), 32'(m_deb));
        check({tag, ".press"}, 32'(bus.press_pulse), 32'(ep));
        check({tag, ".release"}, 32'(bus.release_pulse), 32'(er));
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all("cyc");
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("rst.debounced", 32'(bus.debounced), 32'({N{RL}}));
        check("rst.press", 32'(bus.press_pulse), 32'd0);
        check("rst.release", 32'(bus.release_pulse), 32'd0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Counts edges (first edge after the call is index 0) until debounced reaches target.
    task automatic measure(input string tag, input logic [N-1:0] target);
        int unsigned n = 999;
        bit seen = 1'b0;
        for (int unsigned e = 0; e < 30 && !seen; e++) begin
            step();
            if (bus.debounced == target) begin
                seen = 1'b1;
                n = e;
            end
        end
        check(tag, 32'(n), 32'(D + 1));
    endtask

    logic [N-1:0] exp_p;

    initial begin
        reset = 1'b1;
        bus.button_raw = 2'b11;
        model_reset();
        #1;
        check("init.debounced", 32'(bus.debounced), 32'd0);
        check("init.press", 32'(bus.press_pulse), 32'd0);
        check("init.release", 32'(bus.release_pulse), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        measure("rst_release_lat", 2'b11);

        // Clean press on ch0 only.
        bus.button_raw = 2'b00;
        pulse_reset();
        bus.button_raw = 2'b01;
        measure("press_lat", 2'b01);
`ifdef BUTTON_DEBOUNCER_EDGE_EN
        exp_p = 2'b01;
`else
        exp_p = 2'b00;
`endif
        check("press_pulse_now", 32'(bus.press_pulse), 32'(exp_p));
        step();
        check("press_pulse_gone", 32'(bus.press_pulse), 32'd0);
        repeat (3) step();

        // Glitch rejection: 3 high, 1 low, 3 high, then low.
        bus.button_raw = 2'b00;
        pulse_reset();
        bus.button_raw = 2'b01;
        repeat (3) step();
        bus.button_raw = 2'b00;
        step();
        bus.button_raw = 2'b01;
        repeat (3) step();
        bus.button_raw = 2'b00;
        repeat (8) step();
        check("glitch_hold", 32'(bus.debounced), 32'd0);

        // Simultaneous release on ch0 and press on ch1.
        bus.button_raw = 2'b01;
        pulse_reset();
        measure("pre_swap_lat", 2'b01);
        repeat (2) step();
        bus.button_raw = 2'b10;
        measure("swap_lat", 2'b10);
`ifdef BUTTON_DEBOUNCER_EDGE_EN
        check("swap_release", 32'(bus.release_pulse), 32'h1);
        check("swap_press", 32'(bus.press_pulse), 32'h2);
`else
        check("swap_release", 32'(bus.release_pulse), 32'h0);
        check("swap_press", 32'(bus.press_pulse), 32'h0);
`endif
        repeat (2) step();

        // Reset in the middle of a count must discard it.
        bus.button_raw = 2'b00;
        pulse_reset();
        bus.button_raw = 2'b01;
        repeat (5) step();
        check("mid_count_held", 32'(bus.debounced), 32'd0);
        pulse_reset();
        measure("rst_mid_lat", 2'b01);

        // Random segments with occasional resets.
        for (int unsigned seg = 0; seg < 150; seg++) begin
            bus.button_raw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) pulse_reset();
            repeat ($urandom_range(1, 7)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
